spi_ram_host_ctrl: RTL and testbench
====================================

# spi_ram_host_ctrl

Host-side controller that turns parallel RAM read/write requests into the serial frame sequence expected by the SPI slave with single-port RAM (`MASTER_SPI`). It sits between a processor-style request port and the slave's `SS_n`/`MOSI`/`MISO` pins, and runs in the same `clk` domain. It issues two frames per request, captures read data from `MISO`, and returns a one-cycle completion.

## Interface
- `ADDR_SIZE`, 8: width of RAM address, write data and read data; payload bits per frame.
- `clk` input 1: clock; all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller idle; request accepted when `req_valid && req_ready`.
- `req_wr` input 1: 1 = write, 0 = read.
- `req_addr` input `ADDR_SIZE`: RAM address.
- `req_wdata` input `ADDR_SIZE`: write data (ignored on reads).
- `rsp_valid` output 1: one-cycle completion pulse, for both reads and writes.
- `rsp_rdata` output `ADDR_SIZE`: read data; updated only on read completion, otherwise held.
- `busy` output 1: request in progress (`~req_ready` outside reset).
- `SS_n` output 1: slave select to slave, registered.
- `MOSI` output 1: serial data to slave, registered.
- `MISO` input 1: serial data from slave.

## Operation
- Request latches `req_wr`, `req_addr`, `req_wdata` on acceptance; inputs are don't-care afterwards.
- Write = frame WA (header 000, payload addr) then WD (001, wdata). Read = RA (110, addr) then RD (111, payload all zeros).
- Frame: SEL (1 cycle, `SS_n`=0, `MOSI`=0) -> HDR (3 cycles, header MSB first) -> PAY (`ADDR_SIZE` cycles, payload MSB first) -> [RD only: TURN, `ADDR_SIZE`+1 cycles, `MOSI`=0] -> GAP (1 cycle, `SS_n`=1).
- FSM states: IDLE, SEL, HDR, PAY, TURN, GAP, DONE. A 2-bit phase register tracks WA/WD/RA/RD. Bit counter width is `$clog2(ADDR_SIZE+2)`.
- TURN: cycle 0 is the slave's RAM fetch and is ignored. `MISO` is sampled on cycles 1..`ADDR_SIZE`, MSB first, into a shift register.
- DONE (1 cycle): `rsp_valid`=1. Reads load `rsp_rdata` from the shift register. Then the FSM returns to IDLE.
- `req_ready`=1 only in IDLE. There is no response backpressure.

## Timing
- Reset values: `SS_n`=1, `MOSI`=0, `req_ready`=0 while `rst_n`=0 and 1 in the first IDLE cycle after release, `rsp_valid`=0, `rsp_rdata`=0, `busy`=0.
- Acceptance is at cycle 0; `SS_n` falls at cycle 1.
- Frame lengths with `ADDR_SIZE`=8:
  - WA, WD, RA: 12 cycles low + 1 gap = 13.
  - RD: 21 cycles low + 1 gap = 22.
- `rsp_valid` is high at cycle 27 for a write and cycle 36 for a read. `req_ready` returns the cycle after.
- Reset mid-operation:
  - `SS_n` goes 1 and `MOSI` goes 0 asynchronously.
  - The request is dropped, with no `rsp_valid`.
  - The address cache (below) is invalidated.
- `req_valid` while busy: held off; the master must keep it asserted.

## Configuration
- `SPI_HOST_ADDR_REUSE_EN` defined:
  - Keeps a last-write-address register and a last-read-address register, each with a valid bit, all cleared by reset.
  - WA is skipped if the write address equals the valid last-write address. RA is skipped likewise for reads.
  - A skipped frame shortens the request by 13 cycles (write: `rsp_valid` at cycle 14; read: cycle 23).
- Undefined: every request issues both frames, and no cache registers exist.

## Test plan
- Reset: hold `rst_n`=0 for 20 cycles -> `SS_n`=1, `MOSI`=0, `rsp_valid`=0, `rsp_rdata`=0, `req_ready`=0. Release -> `req_ready`=1 next cycle.
- Write addr 0x3C, data 0xA5 -> `MOSI` carries 0,000,00111100 then 0,001,10100101 with `SS_n` gaps. `rsp_valid` at cycle 27. Slave RAM[0x3C]=0xA5.
- Read addr 0x3C after the write -> headers 110 and 111. `rsp_rdata`=0xA5 with `rsp_valid` at cycle 36. `rsp_rdata` holds through a later write.
- Two writes to 0x10 (data 0x11, 0x22):
  - Macro defined: second `rsp_valid` at cycle 14 after its acceptance.
  - Macro undefined: at cycle 27.
  - Either way, RAM[0x10]=0x22.
- Reset asserted during PAY of a write -> `SS_n`=1 asynchronously and no `rsp_valid`. A following read of 0x3C returns 0xA5 in 36 cycles (WA/RA not skipped).
- `req_valid` held high across a read -> `req_ready` low cycles 1..36. The second request is accepted at cycle 37.

Source files
------------

// File: rtl/spi_ram_host_ctrl.sv
// Serialises RAM read/write requests into two SPI frames each; response pulse at cycle 27 (write) / 36 (read).
// Requests are held off while busy; no response backpressure. Optional SPI_HOST_ADDR_REUSE_EN skips repeated address frames.
module spi_ram_host_ctrl #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int CW = $clog2(ADDR_SIZE + 2);
  localparam int TW = ADDR_SIZE + 3;

  typedef enum logic [2:0] {IDLE, SEL, HDR, PAY, TURN, GAP, DONE} state_t;

  // Phase encoding doubles as the frame header: {p[1], p[1], p[0]}.
  localparam logic [1:0] PH_WA = 2'd0;
  localparam logic [1:0] PH_WD = 2'd1;
  localparam logic [1:0] PH_RA = 2'd2;
  localparam logic [1:0] PH_RD = 2'd3;

  state_t                state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [ADDR_SIZE-1:0]  wdata_q, wdata_d;
  logic [TW-1:0]         tx_q, tx_d;
  logic [ADDR_SIZE-1:0]  rx_q, rx_d;
  logic [ADDR_SIZE-1:0]  rdata_q, rdata_d;
  logic                  ss_n_q, ss_n_d;
  logic                  mosi_q, mosi_d;
  logic                  rdy_en_q, rdy_en_d;
  logic                  skip_wa, skip_ra;
  logic [ADDR_SIZE-1:0]  pay_sel;

`ifdef SPI_HOST_ADDR_REUSE_EN
  logic [ADDR_SIZE-1:0] lwa_q, lwa_d, lra_q, lra_d;
  logic                 lwa_vld_q, lwa_vld_d, lra_vld_q, lra_vld_d;

  assign skip_wa = lwa_vld_q && (req_addr == lwa_q);
  assign skip_ra = lra_vld_q && (req_addr == lra_q);

  always_comb begin
    lwa_d     = lwa_q;
    lwa_vld_d = lwa_vld_q;
    lra_d     = lra_q;
    lra_vld_d = lra_vld_q;
    if (state_q == DONE) begin
      if (phase_q == PH_WD) begin
        lwa_d     = addr_q;
        lwa_vld_d = 1'b1;
      end else begin
        lra_d     = addr_q;
        lra_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lwa_q     <= '0;
      lwa_vld_q <= 1'b0;
      lra_q     <= '0;
      lra_vld_q <= 1'b0;
    end else begin
      lwa_q     <= lwa_d;
      lwa_vld_q <= lwa_vld_d;
      lra_q     <= lra_d;
      lra_vld_q <= lra_vld_d;
    end
  end
`else
  assign skip_wa = 1'b0;
  assign skip_ra = 1'b0;
`endif

  assign req_ready = rdy_en_q && (state_q == IDLE);
  assign busy      = rdy_en_q && (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    rdy_en_d = 1'b1;
    mosi_d   = 1'b0;
    pay_sel  = '0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          phase_d = req_wr ? (skip_wa ? PH_WD : PH_WA) : (skip_ra ? PH_RD : PH_RA);
          state_d = SEL;
        end
      end
      SEL: begin
        state_d = HDR;
        cnt_d   = '0;
      end
      HDR: begin
        if (cnt_q == CW'(2)) begin
          state_d = PAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PAY: begin
        if (cnt_q == CW'(ADDR_SIZE - 1)) begin
          state_d = (phase_q == PH_RD) ? TURN : GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TURN: begin
        // Cycle 0 is the slave's RAM fetch; data bits follow MSB first.
        if (cnt_q != '0) begin
          rx_d = {rx_q[ADDR_SIZE-2:0], MISO};
        end
        if (cnt_q == CW'(ADDR_SIZE)) begin
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        case (phase_q)
          PH_WA: begin
            phase_d = PH_WD;
            state_d = SEL;
          end
          PH_RA: begin
            phase_d = PH_RD;
            state_d = SEL;
          end
          default: begin
            state_d = DONE;
            if (phase_q == PH_RD) begin
              rdata_d = rx_q;
            end
          end
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Header and payload are loaded together on frame entry and shifted out MSB first.
    if (state_d == SEL && state_q != SEL) begin
      if (phase_d == PH_WD) begin
        pay_sel = wdata_d;
      end else if (phase_d != PH_RD) begin
        pay_sel = addr_d;
      end
      tx_d = {phase_d[1], phase_d[1], phase_d[0], pay_sel};
    end else if (state_d == HDR || state_d == PAY) begin
      mosi_d = tx_q[TW-1];
      tx_d   = {tx_q[TW-2:0], 1'b0};
    end

    ss_n_d = !(state_d == SEL || state_d == HDR || state_d == PAY || state_d == TURN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= PH_WA;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      ss_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      ss_n_q   <= ss_n_d;
      mosi_q   <= mosi_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_spi_ram_host_ctrl.sv
// Bench for spi_ram_host_ctrl: behavioural SPI RAM slave, frame-level expectation model, directed requests.
module tb_spi_ram_host_ctrl;

  localparam int A = 8;
`ifdef SPI_HOST_ADDR_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [A-1:0] req_addr;
  logic [A-1:0] req_wdata;
  logic         rsp_valid;
  logic [A-1:0] rsp_rdata;
  logic         busy;
  logic         SS_n;
  logic         MOSI;
  logic         MISO;

  spi_ram_host_ctrl #(.ADDR_SIZE(A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: frame bit 0 is SEL, 1..3 header, 4..11 payload, 12 fetch, 13..20 read data.
  logic [7:0] sram [256];
  int         sidx;
  logic [2:0] shdr;
  logic [7:0] spay, swa, sra, sdat;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n || SS_n) begin
      sidx = 0;
      MISO = 1'b0;
    end else begin
      if (sidx >= 1 && sidx <= 3) shdr = {shdr[1:0], MOSI};
      else if (sidx >= 4 && sidx <= 11) spay = {spay[6:0], MOSI};
      if (sidx == 11) begin
        case (shdr)
          3'b000:  swa = spay;
          3'b001:  sram[swa] = spay;
          3'b110:  sra = spay;
          3'b111:  sdat = sram[sra];
          default: ;
        endcase
      end
      MISO = (sidx >= 13 && sidx <= 20) ? sdat[20-sidx] : 1'b0;
      sidx++;
    end
  end

  // Expectation model: per-cycle line values derived from the request and the frame rules.
  typedef struct packed {
    logic ss_n;
    logic mosi;
    logic rsp;
  } ent_t;

  ent_t       q[$];
  logic [7:0] mram [256];
  logic [7:0] exp_rdata, cur_addr, cur_wdata, cur_rdata, lwa, lra;
  logic       cur_wr, lwa_v, lra_v;

  function automatic void push_frame(input logic [2:0] h, input logic [7:0] p, input bit rd);
    q.push_back('{1'b0, 1'b0, 1'b0});
    for (int i = 2; i >= 0; i--) q.push_back('{1'b0, h[i], 1'b0});
    for (int i = 7; i >= 0; i--) q.push_back('{1'b0, p[i], 1'b0});
    if (rd) for (int i = 0; i < 9; i++) q.push_back('{1'b0, 1'b0, 1'b0});
    q.push_back('{1'b1, 1'b0, 1'b0});
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = 8'h00;
      mram[i] = 8'h00;
    end
  end

  always @(negedge clk) begin
    ent_t e;
    if (!rst_n) begin
      q.delete();
      exp_rdata = 8'h00;
      lwa_v = 1'b0;
      lra_v = 1'b0;
      chk("rst_ss_n", SS_n, 1'b1);
      chk("rst_mosi", MOSI, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rdata", rsp_rdata, exp_rdata);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      if (e.rsp) begin
        if (cur_wr) begin
          mram[cur_addr] = cur_wdata;
          lwa = cur_addr;
          lwa_v = 1'b1;
        end else begin
          exp_rdata = cur_rdata;
          lra = cur_addr;
          lra_v = 1'b1;
        end
      end
      chk("ss_n", SS_n, e.ss_n);
      chk("mosi", MOSI, e.mosi);
      chk("rsp_valid", rsp_valid, e.rsp);
      chk("busy_ready", {busy, req_ready}, 2'b10);
      chk("rdata", rsp_rdata, exp_rdata);
    end else begin
      chk("idle_ss_n", SS_n, 1'b1);
      chk("idle_mosi", MOSI, 1'b0);
      chk("idle_rsp_valid", rsp_valid, 1'b0);
      chk("idle_busy_ready", {busy, req_ready}, 2'b01);
      chk("idle_rdata", rsp_rdata, exp_rdata);
      if (req_valid) begin
        cur_wr = req_wr;
        cur_addr = req_addr;
        cur_wdata = req_wdata;
        if (req_wr) begin
          if (!(REUSE && lwa_v && lwa == req_addr)) push_frame(3'b000, req_addr, 1'b0);
          push_frame(3'b001, req_wdata, 1'b0);
        end else begin
          if (!(REUSE && lra_v && lra == req_addr)) push_frame(3'b110, req_addr, 1'b0);
          push_frame(3'b111, 8'h00, 1'b1);
          cur_rdata = mram[req_addr];
        end
        q.push_back('{1'b1, 1'b0, 1'b1});
      end
    end
  end

  // Issues one request; returns cycles from acceptance to rsp_valid and MOSI bits seen while selected.
  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                        input bit hold, output int lat, output logic [63:0] cap);
    int n;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wr    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
    end
    lat = 0;
    cap = '0;
    do begin
      @(negedge clk);
      lat++;
      if (!SS_n) cap = {cap[62:0], MOSI};
    end while (!rsp_valid && lat < 200);
  endtask

  initial begin
    int          lat;
    logic [63:0] cap;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;

    repeat (20) @(negedge clk);
    chk("lit_rst_ss_n", SS_n, 1'b1);
    chk("lit_rst_ready", req_ready, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_ready_after_release", req_ready, 1'b1);

    do_req(1'b1, 8'h3C, 8'hA5, 1'b0, lat, cap);
    chk("lit_write_latency", lat, 27);
    chk("lit_write_bits", cap[23:0], 24'h03C1A5);
    chk("lit_slave_ram_3c", sram[8'h3C], 8'hA5);

    do_req(1'b0, 8'h3C, 8'h00, 1'b0, lat, cap);
    chk("lit_read_latency", lat, 36);
    chk("lit_read_bits", cap[32:0], {1'b0, 3'b110, 8'h3C, 1'b0, 3'b111, 8'h00, 9'h000});
    chk("lit_read_data", rsp_rdata, 8'hA5);

    do_req(1'b1, 8'h10, 8'h11, 1'b0, lat, cap);
    chk("lit_write_10a_latency", lat, 27);
    chk("lit_rdata_held", rsp_rdata, 8'hA5);
    do_req(1'b1, 8'h10, 8'h22, 1'b0, lat, cap);
    chk("lit_write_10b_latency", lat, REUSE ? 14 : 27);
    chk("lit_slave_ram_10", sram[8'h10], 8'h22);

    // Write interrupted by reset during the address payload.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 8'h3C;
    req_wdata = 8'h5A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("lit_pre_rst_ss_n", SS_n, 1'b0);
    chk("lit_pre_rst_mosi", MOSI, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("lit_async_ss_n", SS_n, 1'b1);
    chk("lit_async_mosi", MOSI, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_req(1'b0, 8'h3C, 8'h00, 1'b0, lat, cap);
    chk("lit_read_after_rst_latency", lat, 36);
    chk("lit_read_after_rst_data", rsp_rdata, 8'hA5);

    // Request held high across a read: second acceptance lands at cycle 37.
    do_req(1'b0, 8'h3C, 8'h00, 1'b1, lat, cap);
    chk("lit_hold_latency", lat, 36);
    chk("lit_hold_ready_at_36", req_ready, 1'b0);
    @(negedge clk);
    chk("lit_hold_ready_at_37", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 200);
    chk("lit_hold_second_latency", lat, REUSE ? 23 : 36);
    chk("lit_hold_second_data", rsp_rdata, 8'hA5);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
